// File: rtl/friet_c_lwc_pkg.sv
// Shared helpers for the FRIET-C LWC buffers: constant width functions
// reused by the input FIFO and the output buffer.
package friet_c_lwc_pkg;

  function automatic int f_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Pointer width; a single-entry store still needs one address bit.
  function automatic int f_ptr_width(input int depth);
    return (depth < 2) ? 1 : f_clog2(depth);
  endfunction

  function automatic int f_cnt_width(input int depth);
    return f_clog2(depth + 1);
  endfunction

endpackage

// File: rtl/friet_c_lwc_fifo_mem.sv
// Register-array storage for the LWC buffer FIFO: one write port and one
// asynchronous read port, no reset so it can become distributed RAM later.
module friet_c_lwc_fifo_mem #(
  parameter int G_WIDTH = 32,
  parameter int G_DEPTH = 4,
  parameter int G_AW    = 2
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [G_AW-1:0]    i_waddr,
  input  logic [G_WIDTH-1:0] i_wdata,
  input  logic [G_AW-1:0]    i_raddr,
  output logic [G_WIDTH-1:0] o_rdata
);

  logic [G_WIDTH-1:0] r_mem [G_DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/friet_c_lwc_buffer_fifo.sv
// Multi-entry valid/ready FIFO between the LWC data inputs and the FRIET-C
// core, with occupancy, almost-full/almost-empty flags and synchronous flush.
module friet_c_lwc_buffer_fifo
  import friet_c_lwc_pkg::*;
#(
  parameter int G_WIDTH        = 32,
  parameter int G_DEPTH        = 4,
  parameter int G_AFULL_LEVEL  = 3,
  parameter int G_AEMPTY_LEVEL = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [G_WIDTH-1:0]                  din,
  input  logic                                din_valid,
  output logic                                din_ready,
  output logic [G_WIDTH-1:0]                  dout,
  output logic                                dout_valid,
  input  logic                                dout_ready,
  output logic [f_cnt_width(G_DEPTH)-1:0]     count,
  output logic                                almost_full,
  output logic                                almost_empty
);

  localparam int LP_AW = f_ptr_width(G_DEPTH);
  localparam int LP_CW = f_cnt_width(G_DEPTH);

  logic [LP_AW-1:0] r_wp;
  logic [LP_AW-1:0] r_rp;
  logic [LP_CW-1:0] r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full = (r_count == LP_CW'(G_DEPTH));

  // When full, a write is only allowed into the slot a same-cycle read frees.
  assign din_ready  = rst & ~flush & (~w_full | dout_ready);
  assign dout_valid = (r_count != {LP_CW{1'b0}});
  assign w_push     = din_valid & din_ready;
  assign w_pop      = dout_valid & dout_ready & ~flush;

  assign count        = r_count;
  assign almost_full  = (r_count >= LP_CW'(G_AFULL_LEVEL));
  assign almost_empty = (r_count <= LP_CW'(G_AEMPTY_LEVEL));

  // Pointer and occupancy state; flush wins over any handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= {LP_AW{1'b0}};
      r_rp    <= {LP_AW{1'b0}};
      r_count <= {LP_CW{1'b0}};
    end else if (flush) begin
      r_wp    <= {LP_AW{1'b0}};
      r_rp    <= {LP_AW{1'b0}};
      r_count <= {LP_CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wp <= r_wp + LP_AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + LP_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CW'(1);
        2'b01:   r_count <= r_count - LP_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  friet_c_lwc_fifo_mem #(
    .G_WIDTH (G_WIDTH),
    .G_DEPTH (G_DEPTH),
    .G_AW    (LP_AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wp),
    .i_wdata (din),
    .i_raddr (r_rp),
    .o_rdata (dout)
  );

endmodule

// File: tb/tb_friet_c_lwc_buffer_fifo.sv
// Directed self-checking bench for friet_c_lwc_buffer_fifo (depth 4, width 32).
module tb_friet_c_lwc_buffer_fifo;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [2:0]  count;
  logic        almost_full;
  logic        almost_empty;

  int n_checks = 0;
  int n_errors = 0;

  friet_c_lwc_buffer_fifo #(
    .G_WIDTH        (32),
    .G_DEPTH        (4),
    .G_AFULL_LEVEL  (3),
    .G_AEMPTY_LEVEL (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; din = 32'h99; din_valid = 1'b1; dout_ready = 1'b0;
    #1 rst = 1'b0;
    tick(); tick();
    chk("rst_din_ready", {31'd0, din_ready}, 32'd0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_aempty", {31'd0, almost_empty}, 32'd1);
    chk("rst_afull", {31'd0, almost_full}, 32'd0);
    rst = 1'b1; din_valid = 1'b0;
    #1;
    chk("idle_din_ready", {31'd0, din_ready}, 32'd1);

    // Fill 0x11..0x44 with consumer stalled
    for (int i = 0; i < 4; i++) begin
      din = 32'h11 * (i + 1); din_valid = 1'b1;
      tick();
      chk("fill_count", {29'd0, count}, i + 1);
      chk("fill_afull", {31'd0, almost_full}, (i + 1 >= 3) ? 32'd1 : 32'd0);
      chk("fill_din_ready", {31'd0, din_ready}, (i + 1 == 4) ? 32'd0 : 32'd1);
      chk("fill_head", dout, 32'h11);
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'd0, dout_valid}, 32'd1);
      chk("drain_dout", dout, 32'h11 * (i + 1));
      tick();
    end
    chk("drain_empty_valid", {31'd0, dout_valid}, 32'd0);
    chk("drain_empty_count", {29'd0, count}, 32'd0);
    chk("drain_aempty", {31'd0, almost_empty}, 32'd1);
    dout_ready = 1'b0;

    // Full streaming
    for (int i = 0; i < 4; i++) begin
      din = 32'hA0 + i; din_valid = 1'b1;
      tick();
    end
    chk("stream_full_count", {29'd0, count}, 32'd4);
    dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din = 32'hB0 + k;
      #1;
      chk("stream_din_ready", {31'd0, din_ready}, 32'd1);
      chk("stream_count", {29'd0, count}, 32'd4);
      chk("stream_dout", dout, (k < 4) ? (32'hA0 + k) : (32'hB0 + k - 4));
      tick();
    end
    din_valid = 1'b0;
    #1;
    for (int k = 4; k < 8; k++) begin
      chk("stream_tail", dout, 32'hB0 + k);
      tick();
    end
    chk("stream_end_valid", {31'd0, dout_valid}, 32'd0);

    // Empty FIFO: push with dout_ready high gives no pop
    din = 32'hC0; din_valid = 1'b1; dout_ready = 1'b1;
    #1;
    chk("empty_no_valid", {31'd0, dout_valid}, 32'd0);
    tick();
    chk("empty_push_count", {29'd0, count}, 32'd1);
    chk("empty_push_dout", dout, 32'hC0);
    // Wrap-around at count 1
    for (int k = 0; k < 10; k++) begin
      din = 32'hC1 + k;
      #1;
      chk("wrap_dout", dout, 32'hC0 + k);
      tick();
      chk("wrap_count", {29'd0, count}, 32'd1);
    end
    chk("wrap_last", dout, 32'hCA);
    din_valid = 1'b0;
    tick();
    chk("wrap_drained", {29'd0, count}, 32'd0);
    dout_ready = 1'b0;

    // Flush at count 3
    for (int i = 0; i < 3; i++) begin
      din = 32'hD0 + i; din_valid = 1'b1;
      tick();
    end
    flush = 1'b1; din = 32'hEE; din_valid = 1'b1; dout_ready = 1'b1;
    #1;
    chk("flush_din_ready", {31'd0, din_ready}, 32'd0);
    chk("flush_dout_valid", {31'd0, dout_valid}, 32'd1);
    chk("flush_count_before", {29'd0, count}, 32'd3);
    tick();
    flush = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_valid", {31'd0, dout_valid}, 32'd0);
    din = 32'h5A; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("post_flush_valid", {31'd0, dout_valid}, 32'd1);
    chk("post_flush_dout", dout, 32'h5A);
    chk("post_flush_count", {29'd0, count}, 32'd1);

    // Asynchronous reset mid-stream at count 2
    din = 32'h6B; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("pre_areset_count", {29'd0, count}, 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("areset_count", {29'd0, count}, 32'd0);
    chk("areset_valid", {31'd0, dout_valid}, 32'd0);
    chk("areset_din_ready", {31'd0, din_ready}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("release_valid", {31'd0, dout_valid}, 32'd0);
    chk("release_count", {29'd0, count}, 32'd0);
    din = 32'h7C; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; dout_ready = 1'b1;
    chk("release_push_dout", dout, 32'h7C);
    chk("release_push_count", {29'd0, count}, 32'd1);
    tick();
    chk("release_pop_valid", {31'd0, dout_valid}, 32'd0);
    dout_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/friet_c_lwc_buffer_fifo.md
Name: friet_c_lwc_buffer_fifo

Overview:
Parametrised multi-entry successor to the single-slot LWC input buffer. It is a valid/ready FIFO of G_DEPTH words of G_WIDTH bits, placed between the LWC public/secret data inputs and the FRIET-C core. It adds occupancy reporting, almost-full/almost-empty flags and a synchronous flush. It keeps the single-slot buffer's zero-bubble, registered-output handshake.

Parameters:
G_WIDTH, 32, data word width in bits (>=1)
G_DEPTH, 4, number of entries; power of two, >=2
G_AFULL_LEVEL, 3, almost_full asserted when count >= this value (1..G_DEPTH)
G_AEMPTY_LEVEL, 1, almost_empty asserted when count <= this value (0..G_DEPTH-1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of all stored words
din  in  G_WIDTH  input word
din_valid  in  1  input word valid
din_ready  out  1  FIFO can accept din this cycle
dout  out  G_WIDTH  head word
dout_valid  out  1  head word valid
dout_ready  in  1  consumer accepts dout this cycle
count  out  CW  stored words, CW = clog2(G_DEPTH+1)
almost_full  out  1  count >= G_AFULL_LEVEL
almost_empty  out  1  count <= G_AEMPTY_LEVEL

Behaviour:
- State registers: write pointer wp and read pointer rp, each log2(G_DEPTH) bits; count, CW bits; storage array mem[G_DEPTH].
- Reset (rst=0, asynchronous): wp=rp=0, count=0. Storage is not reset.
- Outputs while rst=0: din_ready=0, dout_valid=0, count=0, almost_empty=1, almost_full=0.
- Outputs derive only from registered state, except din_ready.
  - dout_valid = (count != 0).
  - dout = mem[rp].
  - din_ready = !flush & ((count != G_DEPTH) | dout_ready).
- push = din_valid & din_ready.
- pop = dout_valid & dout_ready & !flush.
- push: mem[wp] <= din; wp <= wp+1. wp wraps modulo G_DEPTH by natural overflow.
- pop: rp <= rp+1, wrapping the same way.
- count update:
  - push only: count+1
  - pop only: count-1
  - both, or neither: unchanged
- Latency: a word pushed in cycle N is on dout with dout_valid=1 in cycle N+1. There is no combinational din->dout path.
- Empty (count=0): dout_valid=0 and dout_ready is ignored. A push and dout_ready arriving together give no pop; the word appears next cycle.
- Full (count=G_DEPTH): din_ready=dout_ready.
  - A simultaneous push and pop keep count at G_DEPTH and preserve order.
  - The write lands in the slot being vacated (wp==rp). The read of the old value completes in the same cycle.
- flush=1: at the next edge wp=rp=0 and count=0. flush overrides any push or pop in that cycle. din_ready=0 while flush=1. dout_valid still reflects current state, but no pop is counted.
- Reset mid-transfer: any in-flight word is discarded. After release, the first accepted word is dout on the following cycle.
- Ordering is strict FIFO. Data is never duplicated or dropped unless flush or rst is applied.
- All comparisons are unsigned. count never exceeds G_DEPTH or underflows.

Decomposition:
- Shared package/include friet_c_lwc_pkg holds:
  - the clog2 constant function
  - handshake-related localparams (e.g. log2 depth and count width derivation) reused by the output buffer.
- One sub-module: friet_c_lwc_fifo_mem.
  - G_WIDTH x G_DEPTH register array, one write port and one asynchronous read port.
  - No reset.
  - Can be swapped later for a distributed-RAM variant.
- Pointer, count and flag logic stay in the top module.

Test Plan:
- Reset/idle: hold rst=0 with din_valid=1 -> din_ready=0, dout_valid=0, count=0, almost_empty=1; release -> din_ready=1.
- Fill/drain, G_DEPTH=4, dout_ready=0:
  - push 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; din_ready=0 at count 4.
  - then dout_ready=1 -> dout 0x11,0x22,0x33,0x44 on successive cycles; dout_valid=0 after the fourth.
- Full streaming: FIFO full of 0xA0..0xA3, din_valid=dout_ready=1 with 0xB0,0xB1,... -> count stays 4; output order is 0xA0,0xA1,0xA2,0xA3,0xB0,...
- Wrap-around: 10 single push/pop pairs at count 1 -> pointers wrap twice; dout matches input sequence exactly; count stays 1.
- Flush: count=3, assert flush with din_valid=1 and dout_ready=1 for one cycle -> din_ready=0 that cycle; next cycle count=0, dout_valid=0; next push of 0x5A appears on dout one cycle later.
- Async reset mid-stream: drop rst between clock edges at count=2 -> count=0 and dout_valid=0 immediately, without waiting for an edge; after release, no stale word is ever presented.
